bitrev_frame_arbiter: RTL
=========================

Name: bitrev_frame_arbiter

Overview:
- Frame-level scheduler that shares one bitrev core (N = 2^K samples per frame, valid/ready streaming) among NREQ requesters.
- Grants whole input frames round-robin and streams them into the core.
- Queues a requester tag per granted frame and routes each output frame back to the requester that sent it.
- Sits between the requester streams and the bitrev instance; no sample buffering of its own.

Parameters:
- NREQ, 3, number of requesters (>=2).
- K, 10, log2 frame length; must match the bitrev core.
- DW, 32, sample width.
- TAG_DEPTH, 4, in-flight frame tag FIFO depth (power of 2).
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  NREQ  per-requester input sample valid.
- req_data_i  in  NREQ*DW  per-requester input samples.
- req_ready_o  out  NREQ  per-requester input ready.
- rsp_valid_o  out  NREQ  per-requester output sample valid.
- rsp_data_o  out  DW  output sample, shared by all requesters.
- rsp_ready_i  in  NREQ  per-requester output ready.
- core_valid_o / core_data_o[DW] / core_ready_i: drive the core's write side.
- core_valid_i / core_data_i[DW] / core_ready_o: attach to the core's read side.
- busy_o  out  1  a frame is streaming in, or any tag is outstanding.
- frames_done_o  out  CNT_W  count of completed output frames; wraps.

Behaviour:
- Reset (async, rst_i=1):
  - FSM to IDLE; rr_ptr=0; in_cnt=out_cnt=0; tag FIFO emptied; frames_done_o=0.
  - All valid/ready outputs 0.
  - Core must be reset in the same cycle; a reset mid-frame discards all in-flight frames.
- Input FSM, IDLE:
  - All req_ready_o=0 and core_valid_o=0.
  - Grant when any req_valid_i=1 and tag count < TAG_DEPTH.
  - gnt = first asserted requester at or after rr_ptr, modulo NREQ.
  - On grant: gnt_q<=gnt, push gnt onto the tag FIFO, rr_ptr<=(gnt+1)%NREQ, go to STREAM.
  - The first beat can transfer no earlier than the cycle after the grant.
- Input FSM, STREAM:
  - core_valid_o=req_valid_i[gnt_q]; core_data_o=req_data_i[gnt_q]; req_ready_o[gnt_q]=core_ready_i.
  - All other req_ready_o are 0; all paths are combinational.
  - in_cnt increments on each handshake.
  - On the handshake with in_cnt==N-1: in_cnt<=0, return to IDLE.
  - No preemption: a stalled requester keeps the grant indefinitely.
- Output routing:
  - If the tag FIFO is empty: core_ready_o=0 and all rsp_valid_o=0.
  - Otherwise, with head = FIFO head: rsp_valid_o[head]=core_valid_i, core_ready_o=rsp_ready_i[head], other rsp_valid_o=0.
  - rsp_data_o=core_data_i at all times.
  - out_cnt increments per output handshake.
  - On the handshake with out_cnt==N-1: pop, out_cnt<=0, frames_done_o++ (wraps at 2^CNT_W).
- Simultaneous push and pop in one cycle are both performed.
- Full check uses the registered count: no grant when count==TAG_DEPTH, even if a pop occurs that cycle.
- busy_o = (state==STREAM) | (count!=0), registered-state based.
- Output frames leave in the same order their input frames were granted; no reordering.

Decomposition:
- Package bitrev_pkg:
  - state enum {IDLE, STREAM}.
  - Localparam N=2^K, plus tag width $clog2(NREQ).
  - Shared with the core bench.
- One sub-module, bitrev_tag_fifo:
  - Synchronous FIFO of tag-width entries, depth TAG_DEPTH, async active-high reset.
  - Ports: push/pop, head data, count, full, empty.

Test Plan (K=3, N=8, NREQ=3, TAG_DEPTH=2, behavioural core model):
1. Reset: hold rst_i with all inputs 0 -> all outputs 0, frames_done_o=0, busy_o=0. Assert rst_i mid-frame (in_cnt=4) -> outputs 0 within the same cycle, FSM returns to IDLE.
2. Single frame: requester 1 sends 0..7 -> core receives 0..7; requester 1 receives 0,4,2,6,1,5,3,7; rsp_valid_o[0]/[2] stay 0; frames_done_o=1.
3. Round-robin: all three requesters continuously valid -> grant order 0,1,2,0. Each output frame returns to its originator, checked by per-requester data patterns (base values 0x100, 0x200, 0x300).
4. Backpressure:
   - Requester 0 drops valid for 5 cycles mid-frame -> grant held, no beats from others, in_cnt resumes.
   - rsp_ready_i[head]=0 for 10 cycles -> core_ready_o=0, no data lost.
5. Tag full: output side stalled with 2 frames granted -> no third grant, req_ready_o all 0. Releasing one output frame (pop) -> grant the cycle after the count drops.
6. Counter wrap: CNT_W=2, 5 frames -> frames_done_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/bitrev_pkg.sv
// Shared types and constants for the bitrev core and its frame arbiter.
package bitrev_pkg;

    typedef enum logic {
        IDLE,
        STREAM
    } state_e;

    localparam int BITREV_K     = 10;
    localparam int BITREV_N     = 1 << BITREV_K;
    localparam int BITREV_NREQ  = 3;
    localparam int BITREV_TAG_W = $clog2(BITREV_NREQ);

    // Requester tag width; never zero so a 1-requester build still elaborates.
    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/bitrev_tag_fifo.sv
// In-flight frame tag FIFO: one requester id per granted frame, popped when
// that frame has fully left the core.
module bitrev_tag_fifo
    import bitrev_pkg::*;
#(
    parameter int TW    = 2,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [TW-1:0]          push_data_i,
    input  logic                   pop_i,
    output logic [TW-1:0]          head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [TW-1:0] mem_q [DEPTH];
    logic [TW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = push_data_i;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bitrev_frame_arbiter.sv
// Shares one bitrev core among NREQ requesters: round-robin whole-frame grants
// on the write side, tag-ordered routing of output frames on the read side.
module bitrev_frame_arbiter
    import bitrev_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int K         = 10,
    parameter int DW        = 32,
    parameter int TAG_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [DW-1:0]        rsp_data_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic                 core_valid_o,
    output logic [DW-1:0]        core_data_o,
    input  logic                 core_ready_i,
    input  logic                 core_valid_i,
    input  logic [DW-1:0]        core_data_i,
    output logic                 core_ready_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     frames_done_o
);

    localparam int TW = tag_w(NREQ);
    localparam int AW = $clog2(TAG_DEPTH);

    state_e           state_q, state_d;
    logic [TW-1:0]    gnt_q, gnt_d;
    logic [TW-1:0]    rr_q, rr_d;
    logic [K-1:0]     in_cnt_q, in_cnt_d;
    logic [K-1:0]     out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] done_q, done_d;

    logic             gnt_found;
    logic [TW-1:0]    gnt_idx;
    logic             push, pop;
    logic [TW-1:0]    head;
    logic [AW:0]      tag_cnt;
    logic             tag_full, tag_empty;

    bitrev_tag_fifo #(
        .TW    (TW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (gnt_idx),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (tag_cnt),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid_i[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = TW'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        done_d       = done_q;
        push         = 1'b0;
        pop          = 1'b0;
        req_ready_o  = '0;
        core_valid_o = 1'b0;
        core_data_o  = req_data_i[int'(gnt_q)*DW +: DW];
        rsp_valid_o  = '0;
        core_ready_o = 1'b0;

        case (state_q)
            IDLE: begin
                // Full test is on the registered count, so a same-cycle pop
                // does not open a slot until the next cycle.
                if (gnt_found && !tag_full) begin
                    gnt_d   = gnt_idx;
                    push    = 1'b1;
                    rr_d    = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                core_valid_o       = req_valid_i[gnt_q];
                req_ready_o[gnt_q] = core_ready_i;
                if (req_valid_i[gnt_q] && core_ready_i) begin
                    if (&in_cnt_q) begin
                        in_cnt_d = '0;
                        state_d  = IDLE;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!tag_empty) begin
            rsp_valid_o[head] = core_valid_i;
            core_ready_o      = rsp_ready_i[head];
            if (core_valid_i && rsp_ready_i[head]) begin
                if (&out_cnt_q) begin
                    pop       = 1'b1;
                    out_cnt_d = '0;
                    done_d    = done_q + 1'b1;
                end else begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_q      <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            done_q    <= done_d;
        end
    end

    assign rsp_data_o    = core_data_i;
    assign busy_o        = (state_q == STREAM) || (tag_cnt != '0);
    assign frames_done_o = done_q;

endmodule
